sdram_traffic_gen: RTL and testbench



---
 rtl/sdram_traffic_gen.sv | 145 ++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen: LFSR write/read-back traffic generator and checker for the sdram_ctrl_if request port.
// Optional request watchdog enabled by defining SDRAM_TG_TIMEOUT_EN.
module sdram_traffic_gen #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter int          NUM_XFERS   = 1024,
   parameter logic [31:0] SEED        = 32'h1,
   parameter int          ERR_WIDTH   = 16,
   parameter int          TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    mode,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ERR_WIDTH-1:0]    err_count,
   output logic [ADDR_WIDTH-1:0]   first_err_addr,
   output logic                    timeout,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH-1:0]   write_data,
   output logic [DATA_WIDTH/8-1:0] wr,
   output logic                    rd,
   input  logic                    rdy,
   input  logic                    rvalid,
   input  logic [DATA_WIDTH-1:0]   read_data
);
   localparam int SH = $clog2(DATA_WIDTH/8);
   localparam int IW = $clog2(NUM_XFERS+1);
   localparam logic [31:0] TAPS = 32'h80200003;
   localparam logic [31:0] SEED0 = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [ADDR_WIDTH-1:0] MASK = {ADDR_WIDTH{1'b1}} << SH;

   typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} state_t;
   state_t state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d, lfsr_nx, pat;
   logic [63:0] rep;
   logic [IW-1:0] idx_q, idx_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;
   logic [ADDR_WIDTH-1:0] fea_q, fea_d, a_w;
   logic mode_q, mode_d, done_q, done_d, to_q, to_d;
   logic last, miss, evt, fire;

   // In PINGPONG the LFSR already holds the written word once the write is accepted.
   assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
   assign pat     = (mode_q && state_q != WR) ? lfsr_q : lfsr_nx;
   assign rep     = {pat, pat};
   assign a_w     = mode_q ? (ADDR_WIDTH'(pat) & MASK) : (ADDR_WIDTH'(idx_q) << SH);
   assign last    = idx_q == IW'(NUM_XFERS-1);
   assign miss    = read_data != rep[DATA_WIDTH-1:0];
   assign evt     = ((state_q == WR || state_q == RD_REQ) && rdy) || (state_q == RD_WAIT && rvalid);

`ifdef SDRAM_TG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   logic [TW-1:0] wdog_q, wdog_d;
   assign fire   = state_q != IDLE && !evt && wdog_q == TW'(TIMEOUT_CYC-1);
   assign wdog_d = (state_q == IDLE || evt || fire) ? '0 : wdog_q + TW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wdog_q <= '0;
      else        wdog_q <= wdog_d;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= SEED0;
         idx_q   <= '0;
         err_q   <= '0;
         fea_q   <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         fea_q   <= fea_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      idx_d   = idx_q;
      err_d   = err_q;
      fea_d   = fea_q;
      mode_d  = mode_q;
      done_d  = done_q;
      to_d    = to_q;
      if (fire) begin
         state_d = IDLE;
         done_d  = 1'b1;
         to_d    = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d = WR;
               lfsr_d  = SEED0;
               idx_d   = '0;
               err_d   = '0;
               fea_d   = '0;
               mode_d  = mode;
               done_d  = 1'b0;
               to_d    = 1'b0;
            end
            WR: if (rdy) begin
               state_d = (mode_q || last) ? RD_REQ : WR;
               lfsr_d  = (!mode_q && last) ? SEED0 : lfsr_nx;
               idx_d   = mode_q ? idx_q : (last ? '0 : idx_q + IW'(1));
            end
            RD_REQ: if (rdy) state_d = RD_WAIT;
            RD_WAIT: if (rvalid) begin
               err_d   = (miss && !(&err_q)) ? err_q + ERR_WIDTH'(1) : err_q;
               fea_d   = (miss && err_q == '0) ? a_w : fea_q;
               idx_d   = idx_q + IW'(1);
               lfsr_d  = mode_q ? lfsr_q : lfsr_nx;
               state_d = last ? IDLE : (mode_q ? WR : RD_REQ);
               done_d  = last;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy           = state_q != IDLE;
      done           = done_q;
      pass           = done_q && err_q == '0 && !to_q;
      err_count      = err_q;
      first_err_addr = fea_q;
      timeout        = to_q;
      wr             = state_q == WR ? '1 : '0;
      rd             = state_q == RD_REQ;
      addr           = (state_q == WR || state_q == RD_REQ) ? a_w : '0;
      write_data     = state_q == WR ? rep[DATA_WIDTH-1:0] : '0;
   end
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb_sdram_traffic_gen: directed bench with a behavioural memory responder for sdram_traffic_gen.
// Build with SDRAM_TG_TIMEOUT_EN defined to also exercise the watchdog.
module tb_sdram_traffic_gen;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic        rdy = 1'b0, rvalid = 1'b0;
   logic [31:0] read_data = '0;
   logic        busy, done, pass, timeout, rd;
   logic [15:0] err_count;
   logic [31:0] first_err_addr, addr, write_data;
   logic [3:0]  wr;

   sdram_traffic_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_XFERS(16), .SEED(32'h1),
                       .ERR_WIDTH(16), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr), .timeout(timeout),
      .addr(addr), .write_data(write_data), .wr(wr), .rd(rd),
      .rdy(rdy), .rvalid(rvalid), .read_data(read_data));

   always #5 clk = ~clk;

   int passed = 0, total = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory responder: drives rdy/rvalid on the falling edge, logs accepted requests
   int stall_n = 0, stall_cnt = 0;
   bit hold = 0, fault = 0, pend = 0;
   logic [31:0] pend_a;
   logic [68:0] snap;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wa[$], wd[$], ra[$];
   int wcyc[$];
   bit kinds[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         rdy = 0; rvalid = 0; pend = 0; stall_cnt = 0;
      end else begin
         rvalid = 0;
         if (pend) begin
            rvalid = 1;
            read_data = (mem.exists(pend_a) ? mem[pend_a] : 32'h0) ^ ((fault && pend_a == 32'h20) ? 32'h1 : 32'h0);
            pend = 0;
         end
         if (wr != 0 || rd) begin
            if (stall_cnt == 0) snap = {addr, write_data, wr, rd};
            else begin
               total++;
               if (snap !== {addr, write_data, wr, rd}) $display("FAIL hold_stable: got %h want %h", {addr, write_data, wr, rd}, snap);
               else passed++;
            end
            if (hold || stall_cnt < stall_n) begin
               rdy = 0; stall_cnt++;
            end else begin
               rdy = 1; stall_cnt = 0;
               if (wr != 0) begin
                  mem[addr] = write_data;
                  wa.push_back(addr); wd.push_back(write_data); wcyc.push_back(cyc); kinds.push_back(0);
               end else begin
                  ra.push_back(addr); kinds.push_back(1); pend = 1; pend_a = addr;
               end
            end
         end else rdy = 0;
      end
   end

   function automatic logic [31:0] step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
   endfunction

   task automatic clear_logs;
      wa.delete(); wd.delete(); ra.delete(); wcyc.delete(); kinds.delete();
   endtask

   task automatic kick(input logic m);
      @(negedge clk);
      mode = m; start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_done(input string name);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      total++;
      if (!ok) $display("FAIL %s_done_wait: got done=%b want 1 within 2000 cycles", name, done);
      else passed++;
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      total++; if ({busy, done, pass, timeout, wr, rd} !== 10'h0) $display("FAIL reset_flags: got %b want 0", {busy, done, pass, timeout, wr, rd}); else passed++;
      total++; if ({err_count, first_err_addr} !== 48'h0) $display("FAIL reset_stats: got %h want 0", {err_count, first_err_addr}); else passed++;
      total++; if ({addr, write_data} !== 64'h0) $display("FAIL reset_req: got %h want 0", {addr, write_data}); else passed++;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_block;
      logic [31:0] x = 32'h1;
      clear_logs();
      kick(0);
      total++; if ({busy, done, wr, rd} !== 7'b1011110) $display("FAIL block_start: got %b want 1011110", {busy, done, wr, rd}); else passed++;
      total++; if (addr !== 32'h0 || write_data !== 32'h80200003) $display("FAIL block_first_req: got %h/%h want 00000000/80200003", addr, write_data); else passed++;
      wait_done("block");
      total++; if ({done, pass, err_count} !== {2'b11, 16'h0}) $display("FAIL block_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); else passed++;
      total++; if ({busy, wr, rd} !== 6'h0) $display("FAIL block_idle: got %b want 0", {busy, wr, rd}); else passed++;
      total++; if (wa.size() != 16 || ra.size() != 16) $display("FAIL block_counts: got %0d/%0d want 16/16", wa.size(), ra.size()); else passed++;
      total++; if (wd.size() > 1 && wd[1] !== 32'hC0300002) $display("FAIL block_second_data: got %h want c0300002", wd[1]); else passed++;
      for (int i = 0; i < 16 && i < wa.size() && i < ra.size(); i++) begin
         x = step(x);
         total++;
         if (wa[i] !== 32'(i * 4) || wd[i] !== x || ra[i] !== 32'(i * 4))
            $display("FAIL block_word%0d: got wa=%h wd=%h ra=%h want %h/%h/%h", i, wa[i], wd[i], ra[i], 32'(i * 4), x, 32'(i * 4));
         else passed++;
      end
      total++; if (wcyc.size() == 16 && wcyc[15] - wcyc[0] != 15) $display("FAIL block_back_to_back: got span %0d want 15", wcyc[15] - wcyc[0]); else passed++;
   endtask

   task automatic test_pingpong;
      logic [31:0] x = 32'h1;
      clear_logs();
      kick(1);
      total++; if (addr !== 32'h80200000 || write_data !== 32'h80200003) $display("FAIL pp_first_req: got %h/%h want 80200000/80200003", addr, write_data); else passed++;
      wait_done("pp");
      total++; if ({done, pass, err_count} !== {2'b11, 16'h0}) $display("FAIL pp_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); else passed++;
      total++; if (wa.size() != 16 || ra.size() != 16 || kinds.size() != 32) $display("FAIL pp_counts: got %0d/%0d/%0d want 16/16/32", wa.size(), ra.size(), kinds.size()); else passed++;
      for (int i = 0; i < 16 && i < wa.size() && i < ra.size(); i++) begin
         x = step(x);
         total++;
         if (wa[i] !== (x & 32'hFFFFFFFC) || wd[i] !== x || ra[i] !== wa[i] || kinds[2*i] !== 1'b0 || kinds[2*i+1] !== 1'b1)
            $display("FAIL pp_pair%0d: got wa=%h wd=%h ra=%h want %h/%h/%h", i, wa[i], wd[i], ra[i], x & 32'hFFFFFFFC, x, x & 32'hFFFFFFFC);
         else passed++;
      end
   endtask

   task automatic test_fault;
      fault = 1;
      clear_logs();
      kick(0);
      wait_done("fault");
      total++; if (err_count !== 16'd1) $display("FAIL fault_count: got %0d want 1", err_count); else passed++;
      total++; if (first_err_addr !== 32'h20) $display("FAIL fault_addr: got %h want 00000020", first_err_addr); else passed++;
      total++; if ({done, pass} !== 2'b10) $display("FAIL fault_pass: got %b want 10", {done, pass}); else passed++;
      fault = 0;
   endtask

   task automatic test_backpressure;
      stall_n = 5;
      clear_logs();
      kick(0);
      wait_done("bp");
      total++; if ({done, pass, err_count} !== {2'b11, 16'h0}) $display("FAIL bp_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); else passed++;
      total++; if (wa.size() != 16 || ra.size() != 16 || wa[15] !== 32'h3C || ra[15] !== 32'h3C) $display("FAIL bp_addrs: got %0d writes last %h want 16 last 0000003c", wa.size(), wa[wa.size()-1]); else passed++;
      total++; if (wcyc.size() > 1 && wcyc[1] - wcyc[0] != 6) $display("FAIL bp_spacing: got %0d want 6", wcyc[1] - wcyc[0]); else passed++;
      stall_n = 0;
   endtask

   task automatic test_reset_mid;
      bit found = 0;
      clear_logs();
      kick(0);
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (ra.size() == 8 && busy && !rd && wr == 0) begin found = 1; break; end
      end
      total++; if (!found) $display("FAIL midrst_reach: got reads=%0d want RD_WAIT of word 7", ra.size()); else passed++;
      rst_n = 0;
      #1;
      total++; if ({busy, done, pass, timeout, wr, rd, err_count, first_err_addr, addr, write_data} !== 122'h0)
         $display("FAIL midrst_outputs: got busy=%b wr=%h rd=%b addr=%h want all 0", busy, wr, rd, addr); else passed++;
      @(negedge clk);
      rst_n = 1;
      clear_logs();
      kick(0);
      wait_done("midrst");
      total++; if ({pass, err_count} !== {1'b1, 16'h0} || wa.size() != 16) $display("FAIL midrst_rerun: got pass=%b err=%0d writes=%0d want 1 0 16", pass, err_count, wa.size()); else passed++;
   endtask

`ifdef SDRAM_TG_TIMEOUT_EN
   task automatic test_timeout;
      int k;
      hold = 1;
      clear_logs();
      kick(0);
      for (k = 1; k < 200; k++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      total++; if (k != 64) $display("FAIL to_latency: got %0d want 64", k); else passed++;
      total++; if ({done, timeout, pass, busy, wr} !== 8'b11000000) $display("FAIL to_flags: got %b want 11000000", {done, timeout, pass, busy, wr}); else passed++;
      hold = 0;
      kick(0);
      total++; if (timeout !== 1'b0 || done !== 1'b0) $display("FAIL to_clear: got timeout=%b done=%b want 0 0", timeout, done); else passed++;
      wait_done("to_rerun");
      total++; if (pass !== 1'b1) $display("FAIL to_rerun_pass: got %b want 1", pass); else passed++;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_block();
      test_pingpong();
      test_fault();
      test_backpressure();
      test_reset_mid();
`ifdef SDRAM_TG_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
